// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch, hazard and resolution signals of the branch predictor
interface branch_predict_unit_if #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W = 16
);
  logic [31:0] pc_f;
  logic fetch_valid;
  logic stall;
  logic flush;
  logic prediction_d;
  logic [INDEX_BITS-1:0] pred_idx_d;
  logic valid_d;
  logic update_en;
  logic [INDEX_BITS-1:0] update_idx;
  logic update_pred;
  logic actual_taken;
  logic [CNT_W-1:0] mispredict_cnt;
  modport master (
    output pc_f, fetch_valid, stall, flush, update_en, update_idx, update_pred, actual_taken,
    input prediction_d, pred_idx_d, valid_d, mispredict_cnt
  );
  modport slave (
    input pc_f, fetch_valid, stall, flush, update_en, update_idx, update_pred, actual_taken,
    output prediction_d, pred_idx_d, valid_d, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit saturating BHT predictor with IF/ID prediction register; BPU_GSHARE_EN adds gshare indexing
module branch_predict_unit #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  branch_predict_unit_if.slave bus
);
  localparam int N = 1 << INDEX_BITS;
  logic [1:0] bht [N];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic predicted;
  logic [1:0] cur;
  logic [1:0] nxt;
  logic unused_pc;
  assign unused_pc = ^{bus.pc_f[31:INDEX_BITS+2], bus.pc_f[1:0]};
`ifdef BPU_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;
  // global history shifts in each resolved outcome, independent of stall/flush
  always_ff @(posedge clk or posedge rst)
    if (rst) ghr <= '0;
    else if (bus.update_en) ghr <= {ghr[INDEX_BITS-2:0], bus.actual_taken};
  assign lookup_idx = bus.pc_f[INDEX_BITS+1:2] ^ ghr;
`else
  assign lookup_idx = bus.pc_f[INDEX_BITS+1:2];
`endif
  assign predicted = bht[lookup_idx][1] & bus.fetch_valid;
  assign cur = bht[bus.update_idx];
  // saturating step toward the resolved outcome
  always_comb nxt = bus.actual_taken ? (&cur ? cur : cur + 2'd1) : (|cur ? cur - 2'd1 : cur);
  // BHT write; the fetch lookup above sees the pre-update value
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) bht[i] <= 2'b01;
    else if (bus.update_en) bht[bus.update_idx] <= nxt;
  // IF/ID prediction register: stall holds, then flush clears
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.prediction_d <= 1'b0;
      bus.pred_idx_d <= '0;
      bus.valid_d <= 1'b0;
    end else if (!bus.stall) begin
      bus.prediction_d <= bus.flush ? 1'b0 : predicted;
      bus.pred_idx_d <= bus.flush ? '0 : lookup_idx;
      bus.valid_d <= bus.flush ? 1'b0 : bus.fetch_valid;
    end
  // saturating mispredict counter
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.mispredict_cnt <= '0;
    else if (bus.update_en && (bus.update_pred != bus.actual_taken) && !(&bus.mispredict_cnt))
      bus.mispredict_cnt <= bus.mispredict_cnt + 1'b1;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: table vectors, hand sequences and random stimulus against a behavioural model
module tb_branch_predict_unit;
  localparam int IB = 6;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int m_bht [64];
  int m_pred, m_idx, m_valid, m_cnt, m_ghr;
  typedef struct {
    int pc, fv, st, fl, ue, uidx, up, at;
    int ep, ei, ev, ec;
  } vec_t;
  vec_t tbl [16];
  branch_predict_unit_if #(.INDEX_BITS(IB), .CNT_W(CW)) bus ();
  branch_predict_unit #(.INDEX_BITS(IB), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_pred = 0; m_idx = 0; m_valid = 0; m_cnt = 0; m_ghr = 0;
  endtask

  task automatic model_edge();
    int li;
    int p;
    int t;
    li = ((bus.pc_f >> 2) & 63) ^ m_ghr;
    p = (m_bht[li] >= 2 && bus.fetch_valid) ? 1 : 0;
    if (!bus.stall) begin
      if (bus.flush) begin m_pred = 0; m_idx = 0; m_valid = 0; end
      else begin m_pred = p; m_idx = li; m_valid = bus.fetch_valid ? 1 : 0; end
    end
    if (bus.update_en) begin
      t = int'(bus.update_idx);
      m_bht[t] = bus.actual_taken ? (m_bht[t] == 3 ? 3 : m_bht[t] + 1) : (m_bht[t] == 0 ? 0 : m_bht[t] - 1);
      if (bus.update_pred != bus.actual_taken && m_cnt < CMAX) m_cnt++;
`ifdef BPU_GSHARE_EN
      m_ghr = ((m_ghr << 1) | (bus.actual_taken ? 1 : 0)) & 63;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".prediction_d"}, 32'(bus.prediction_d), m_pred);
    chk({tag, ".pred_idx_d"}, 32'(bus.pred_idx_d), m_idx);
    chk({tag, ".valid_d"}, 32'(bus.valid_d), m_valid);
    chk({tag, ".mispredict_cnt"}, 32'(bus.mispredict_cnt), m_cnt);
  endtask

  task automatic drive(input int pc, fv, st, fl, ue, uidx, up, at);
    bus.pc_f = pc;
    bus.fetch_valid = fv[0];
    bus.stall = st[0];
    bus.flush = fl[0];
    bus.update_en = ue[0];
    bus.update_idx = uidx[IB-1:0];
    bus.update_pred = up[0];
    bus.actual_taken = at[0];
  endtask

  task automatic step(input string tag, input int pc, fv, st, fl, ue, uidx, up, at);
    drive(pc, fv, st, fl, ue, uidx, up, at);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 0;
    tbl[0]  = '{32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 16, 1, 0};
    tbl[1]  = '{32'h00, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0, 1};
    tbl[2]  = '{32'h00, 0, 0, 0, 1, 16, 1, 1, 0, 0, 0, 1};
    tbl[3]  = '{32'h40, 1, 0, 0, 0, 0, 0, 0, 1, 16, 1, 1};
    tbl[4]  = '{32'h40, 1, 0, 0, 1, 16, 1, 0, 1, 16, 1, 2};
    tbl[5]  = '{32'h40, 1, 0, 0, 1, 16, 0, 0, 1, 16, 1, 2};
    tbl[6]  = '{32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 16, 1, 2};
    tbl[7]  = '{32'h00, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 2};
    tbl[8]  = '{32'h0C, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 2};
    tbl[9]  = '{32'h40, 1, 1, 0, 0, 0, 0, 0, 1, 3, 1, 2};
    tbl[10] = '{32'h80, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 2};
    tbl[11] = '{32'h44, 1, 1, 1, 0, 0, 0, 0, 1, 3, 1, 2};
    tbl[12] = '{32'h0C, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[13] = '{32'h14, 1, 0, 0, 1, 5, 1, 1, 0, 5, 1, 2};
    tbl[14] = '{32'h17, 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 2};
    tbl[15] = '{32'h0C, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2};
    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].st, tbl[i].fl,
           tbl[i].ue, tbl[i].uidx, tbl[i].up, tbl[i].at);
`ifndef BPU_GSHARE_EN
      chk($sformatf("vec%0d.exp_pred", i), 32'(bus.prediction_d), tbl[i].ep);
      chk($sformatf("vec%0d.exp_idx", i), 32'(bus.pred_idx_d), tbl[i].ei);
      chk($sformatf("vec%0d.exp_valid", i), 32'(bus.valid_d), tbl[i].ev);
      chk($sformatf("vec%0d.exp_cnt", i), 32'(bus.mispredict_cnt), tbl[i].ec);
`endif
    end
    for (int i = 0; i < (1 << CW) + 3; i++) step("sat", 0, 0, 0, 0, 1, 10, i & 1, ~i & 1);
    chk("sat.cnt_max", 32'(bus.mispredict_cnt), CMAX);
    for (int i = 0; i < 4; i++) step("correct", 0, 0, 0, 0, 1, 10, i & 1, i & 1);
    chk("correct.cnt_hold", 32'(bus.mispredict_cnt), CMAX);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom, ($urandom_range(3) != 0) ? 1 : 0, ($urandom_range(5) == 0) ? 1 : 0,
           ($urandom_range(7) == 0) ? 1 : 0, $urandom_range(1), $urandom_range(63),
           $urandom_range(1), $urandom_range(1));
    drive(32'h40, 1, 0, 0, 1, 16, 0, 1);
    @(posedge clk);
    #3;
    rst = 1;
    model_reset();
    #1;
    check_model("midrst");
    @(posedge clk);
    #1;
    check_model("midrst_hold");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      step("postrst", $urandom, 1, 0, 0, 0, 0, 0, 0);
      chk("postrst.not_taken", 32'(bus.prediction_d), 0);
    end
`ifdef BPU_GSHARE_EN
    @(negedge clk);
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
    step("ghr1", 0, 0, 0, 0, 1, 0, 0, 1);
    step("ghr2", 0, 0, 0, 0, 1, 0, 0, 0);
    step("ghr3", 0, 0, 0, 0, 1, 0, 0, 1);
    step("ghr_fetch", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ghr_fetch.idx5", 32'(bus.pred_idx_d), 5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
